// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the multi-cycle signed divide sequencer.
//   - div_state_e : sequencer state encoding (IDLE, ITER, FIXUP, DONE)
//   - DIV_WIDTH   : operand width of the divide path
//   - DIV_DZ_QUOT : quotient returned when the divisor is zero
//   - abs_w       : two's-complement magnitude, returned as an unsigned value
//   - neg_if      : conditional two's-complement negate
// The helper functions work at DIV_WIDTH bits. The sequencer's WIDTH
// parameter is expected to stay equal to DIV_WIDTH.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // The most-negative input maps to 2^(W-1), which is representable
    // when the result is read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_w(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v,
                                                    input logic              neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration. This block is purely combinational.
// The {R,Q} pair is shifted left by one bit. The divisor is then trial-
// subtracted from the shifted remainder. The result is kept only when it
// is non-negative, and the new quotient bit records whether it was kept.
//
// Ports:
//   r_i      [WIDTH-1:0]  partial remainder (invariant: r_i < d_i)
//   q_i      [WIDTH-1:0]  dividend / developing quotient
//   d_i      [WIDTH-1:0]  divisor magnitude (non-zero)
//   r_next_o [WIDTH-1:0]  remainder after this step
//   q_next_o [WIDTH-1:0]  quotient after this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_next_o,
    output logic [WIDTH-1:0] q_next_o
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;
    logic           trial_neg;

    // The bit shifted out of Q becomes the new LSB of R.
    assign r_shift = {r_i, q_i[WIDTH-1]};

    // R < D holds on entry, so r_shift fits in WIDTH bits. As a result,
    // bit WIDTH of the difference is a reliable sign bit.
    assign trial     = r_shift - {1'b0, d_i};
    assign trial_neg = trial[WIDTH];

    assign r_next_o = trial_neg ? {r_i[WIDTH-2:0], q_i[WIDTH-1]} : trial[WIDTH-1:0];
    assign q_next_o = {q_i[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Multi-cycle sequencer for the signed divide path. It produces one quotient
// bit per clock. The result matches Verilog signed '/' and '%':
//   - the quotient truncates toward zero;
//   - the remainder takes the sign of the dividend.
// The packed result is {remainder, quotient}.
//
// Parameters:
//   WIDTH    operand width (keep equal to div_pkg::DIV_WIDTH)
//   DZ_QUOT  quotient returned on divide-by-zero
//
// Ports:
//   clock     in   system clock, rising edge
//   clear     in   synchronous active-high reset; overrides every other input
//   start     in   divide request; only honoured in IDLE
//   dividend  in   signed dividend, sampled on the accepting edge
//   divisor   in   signed divisor, sampled on the accepting edge
//   abort     in   (DIV_SEQ_ABORT_EN only) abandon an operation in ITER/FIXUP
//   busy      out  high from the cycle after acceptance through the DONE cycle
//   done      out  one-cycle pulse, result valid
//   div_zero  out  set with done when the divisor was zero; held until the
//                  next acceptance
//   result    out  {remainder, quotient}; held until the next done or clear
//
// Optional feature: defining the macro DIV_SEQ_ABORT_EN adds the abort port.
//
// Timing with the accepting edge numbered 0:
//   - a normal divide spends WIDTH edges in ITER and one edge in FIXUP,
//     so done is high after edge WIDTH+1;
//   - a divide-by-zero goes straight to FIXUP, so done is high after edge 1.
// -----------------------------------------------------------------------------
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int               WIDTH   = DIV_WIDTH,
    parameter logic [WIDTH-1:0] DZ_QUOT = DIV_DZ_QUOT
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
`ifdef DIV_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int             CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e         state_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   r_q;        // partial remainder, or raw dividend on divide-by-zero
    logic [WIDTH-1:0]   q_q;        // |dividend| shifting into the quotient
    logic [WIDTH-1:0]   d_q;        // |divisor|
    logic               qneg_q;     // quotient must be negated at fixup
    logic               rneg_q;     // remainder must be negated at fixup
    logic               dz_q;       // current operation is a divide-by-zero
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               abort_w;

`ifdef DIV_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r_i      (r_q),
        .q_i      (q_q),
        .d_i      (d_q),
        .r_next_o (r_d),
        .q_next_o (q_d)
    );

    // Sign correction applied in FIXUP. On a divide-by-zero, r_q holds the
    // original dividend, which is returned unchanged as the remainder.
    always_comb begin
        quot_fix = neg_if(q_q, qneg_q);
        rem_fix  = neg_if(r_q, rneg_q);
        if (dz_q) begin
            quot_fix = DZ_QUOT;
            rem_fix  = r_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            count_q    <= '0;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        count_q    <= '0;
                        if (divisor == '0) begin
                            dz_q    <= 1'b1;
                            r_q     <= dividend;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= FIXUP;
                        end else begin
                            dz_q    <= 1'b0;
                            r_q     <= '0;
                            q_q     <= abs_w(dividend);
                            d_q     <= abs_w(divisor);
                            qneg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rneg_q  <= dividend[WIDTH-1];
                            state_q <= ITER;
                        end
                    end
                end

                ITER: begin
                    if (abort_w) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        r_q     <= r_d;
                        q_q     <= q_d;
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_STEP) begin
                            state_q <= FIXUP;
                        end
                    end
                end

                FIXUP: begin
                    if (abort_w) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        result_q   <= {rem_fix, quot_fix};
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                        state_q    <= DONE;
                    end
                end

                DONE: begin
                    // A start in this cycle is deliberately dropped. The next
                    // acceptance happens in the following IDLE cycle.
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign result   = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
// Directed bench for div_seq_ctrl. Each expected value is a hand-computed
// constant taken from signed-division arithmetic. Each comparison point
// is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIV_SEQ_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    div_seq_ctrl dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
`ifdef DIV_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .result   (result)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pulses start for one edge, then scrambles the operands. It returns:
    //   lat  : number of edges after the accepting edge until done is seen;
    //   bcyc : number of sampled cycles with busy high, done cycle included.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0BAD_F00D;
        lat  = 0;
        bcyc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) bcyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int bcyc;
        int n;
        int n1;
        int dcnt;

        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        tick();
        tick();
        clear = 1'b0;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_result", result, 64'd0);

        // 7 / 2
        do_div(32'd7, 32'd2, lat, bcyc);
        check("7/2_lat", 64'(lat), 64'd33);
        check("7/2_busy_cyc", 64'(bcyc), 64'd34);
        check("7/2_result", result, 64'h00000001_00000003);
        check("7/2_dz", 64'(div_zero), 64'd0);
        tick();
        check("7/2_done_pulse", 64'(done), 64'd0);
        check("7/2_busy_end", 64'(busy), 64'd0);

        // -7 / 2 and 7 / -2
        do_div(32'hFFFF_FFF9, 32'd2, lat, bcyc);
        check("-7/2_result", result, 64'hFFFFFFFF_FFFFFFFD);
        tick();
        do_div(32'd7, 32'hFFFF_FFFE, lat, bcyc);
        check("7/-2_result", result, 64'h00000001_FFFFFFFD);
        tick();

        // 7 / 0
        do_div(32'd7, 32'd0, lat, bcyc);
        check("7/0_lat", 64'(lat), 64'd1);
        check("7/0_busy_cyc", 64'(bcyc), 64'd2);
        check("7/0_result", result, 64'h00000007_FFFFFFFF);
        check("7/0_dz", 64'(div_zero), 64'd1);
        tick();
        check("7/0_dz_held", 64'(div_zero), 64'd1);
        check("7/0_done_pulse", 64'(done), 64'd0);

        // Most-negative operand cases.
        do_div(32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
        check("min/-1_result", result, 64'h00000000_80000000);
        check("min/-1_dz", 64'(div_zero), 64'd0);
        tick();
        do_div(32'h8000_0000, 32'd1, lat, bcyc);
        check("min/1_result", result, 64'h00000000_80000000);
        tick();

        // start while busy is ignored: 100/7, with a 9/3 pulse at edge 10.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        repeat (9) tick();            // edges 1..9
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();                       // edge 10
        start = 1'b0;
        n = 10;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("ign_lat", 64'(n), 64'd33);
        check("ign_result", result, 64'h00000002_0000000E);
        tick();

        // clear at edge 20 of a 100/7 operation.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        repeat (19) tick();           // edges 1..19
        clear = 1'b1;
        tick();                       // edge 20
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_result", result, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("clr_no_done", 64'(dcnt), 64'd0);

        // clear and start on the same edge: start must not be accepted.
        dividend = 32'd9;
        divisor  = 32'd3;
        clear    = 1'b1;
        start    = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        tick();
        check("clr_start_busy", 64'(busy), 64'd0);

        // Back-to-back with start held high: 100/7, then 9/3.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();                       // edge 0
        dividend = 32'd9;
        divisor  = 32'd3;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        n1 = n;
        check("b2b_first_lat", 64'(n1), 64'd33);
        check("b2b_first_res", result, 64'h00000002_0000000E);
        tick();                       // DONE -> IDLE, start ignored
        n++;
        check("b2b_idle_gap", 64'(busy), 64'd0);
        while (!done && n < 200) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("b2b_spacing", 64'(n - n1), 64'd35);
        check("b2b_second_res", result, 64'h00000000_00000003);
        tick();

`ifdef DIV_SEQ_ABORT_EN
        // abort at edge 5: no done, and the prior result is kept.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        repeat (4) tick();            // edges 1..4
        abort = 1'b1;
        tick();                       // edge 5
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        check("abort_result", result, 64'h00000000_00000003);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
